axi_ic_aw_w_sched: RTL and testbench

Per-slave write-path scheduler for the AXI interconnect. It round-robin arbitrates AW requests from all masters targeting one slave and drives the AW mux select. It records each accepted AW's master index in order so the W mux follows AW order until WLAST. It caps in-flight writes by counting AW acceptances against B completions, so the B return path never sees more responses than it can route. One instance sits on each slave port, in front of the AW/W muxes.

---
 rtl/axi_ic_aw_w_sched.sv | 143 ++++++++++++++
 tb/tb_axi_ic_aw_w_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ic_aw_w_sched.sv
// Per-slave AXI write scheduler: round-robin AW arbitration, in-order W routing FIFO,
// and an in-flight write cap. Sticky err_o flags W/B/AW protocol violations.
//   state   | meaning
//   IDLE    | no AW routed; arbitrate when requests present and capacity allows
//   GRANT   | AW path routed to aw_sel_o until the slave accepts the request
module axi_ic_aw_w_sched #(
  parameter int NumMasters     = 2,
  parameter int MaxOutstanding = 4,
  parameter int IdxWidth       = ($clog2(NumMasters) == 0) ? 1 : $clog2(NumMasters),
  localparam int CntWidth      = $clog2(MaxOutstanding + 1),
  localparam int PtrWidth      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
  input  logic                  aclk,
  input  logic                  rst_n,
  input  logic [NumMasters-1:0] aw_req_i,
  input  logic                  slv_awready_i,
  output logic [IdxWidth-1:0]   aw_sel_o,
  output logic                  aw_sel_valid_o,
  output logic [NumMasters-1:0] aw_gnt_o,
  input  logic                  w_hs_i,
  input  logic                  wlast_i,
  output logic [IdxWidth-1:0]   w_sel_o,
  output logic                  w_sel_valid_o,
  input  logic                  b_hs_i,
  output logic [CntWidth-1:0]   outstanding_o,
  output logic                  err_o
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumMasters - 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);

  state_t              state_q, state_d;
  logic [IdxWidth-1:0] sel_q, sel_d, rr_q, rr_d;
  logic [IdxWidth-1:0] winner, hi_idx, any_idx;
  logic                hi_found;
  logic                arb_fire, aw_hs, sel_req;

  logic [IdxWidth-1:0] fifo_mem [MaxOutstanding];
  logic [PtrWidth-1:0] wr_ptr, rd_ptr;
  logic [CntWidth-1:0] fifo_cnt, out_cnt;
  logic                fifo_empty, push, pop, b_dec, err_q;

  // Lowest requester at or above the rr pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_idx   = '0;
    any_idx  = '0;
    hi_found = 1'b0;
    for (int i = NumMasters - 1; i >= 0; i--) begin
      if (aw_req_i[i]) begin
        any_idx = IdxWidth'(i);
        if (IdxWidth'(i) >= rr_q) begin
          hi_idx   = IdxWidth'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_idx : any_idx;
  end

  assign fifo_empty = (fifo_cnt == '0);
  assign sel_req    = aw_req_i[sel_q];
  assign arb_fire   = (state_q == ST_IDLE) && (|aw_req_i) && (out_cnt < MaxCnt) && (fifo_cnt < MaxCnt);
  assign aw_hs      = (state_q == ST_GRANT) && sel_req && slv_awready_i;
  assign push       = aw_hs;
  assign pop        = w_hs_i && wlast_i && !fifo_empty;
  assign b_dec      = b_hs_i && (out_cnt != '0);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_fire) begin
          sel_d   = winner;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (aw_hs) begin
          rr_d    = (sel_q == LastIdx) ? '0 : sel_q + IdxWidth'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < MaxOutstanding; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= sel_q;
        wr_ptr           <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrWidth'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrWidth'(1);
      if (push && !pop) fifo_cnt <= fifo_cnt + CntWidth'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CntWidth'(1);
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (aw_hs && !b_dec && (out_cnt < MaxCnt)) out_cnt <= out_cnt + CntWidth'(1);
      else if (b_dec && !aw_hs) out_cnt <= out_cnt - CntWidth'(1);
      // A dropped valid in GRANT is flagged, but the grant is held regardless.
      if ((w_hs_i && fifo_empty) || (b_hs_i && (out_cnt == '0)) ||
          ((state_q == ST_GRANT) && !sel_req))
        err_q <= 1'b1;
    end
  end

  assign aw_sel_o       = sel_q;
  assign aw_sel_valid_o = (state_q == ST_GRANT);
  assign aw_gnt_o       = (NumMasters'(1) << sel_q) & {NumMasters{aw_sel_valid_o && slv_awready_i}};
  assign w_sel_o        = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign w_sel_valid_o  = !fifo_empty;
  assign outstanding_o  = out_cnt;
  assign err_o          = err_q;

endmodule

// File: tb/tb_axi_ic_aw_w_sched.sv
// Randomized bench for axi_ic_aw_w_sched: a queue-based reference model predicts grant
// order, W routing order, outstanding count and error flag; a monitor checks the order queues.
module tb_axi_ic_aw_w_sched;
  localparam int N   = 2;
  localparam int MAX = 4;
  localparam int IW  = 1;
  localparam int CW  = 3;

  logic          aclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  aw_req = '0;
  logic          slv_awready = 1'b0, w_hs = 1'b0, wlast = 1'b0, b_hs = 1'b0;
  logic [IW-1:0] aw_sel, w_sel;
  logic          aw_sel_valid, w_sel_valid, err;
  logic [N-1:0]  aw_gnt;
  logic [CW-1:0] outstanding;

  always #5 aclk = ~aclk;

  axi_ic_aw_w_sched #(.NumMasters(N), .MaxOutstanding(MAX)) dut (
    .aclk(aclk), .rst_n(rst_n),
    .aw_req_i(aw_req), .slv_awready_i(slv_awready),
    .aw_sel_o(aw_sel), .aw_sel_valid_o(aw_sel_valid), .aw_gnt_o(aw_gnt),
    .w_hs_i(w_hs), .wlast_i(wlast),
    .w_sel_o(w_sel), .w_sel_valid_o(w_sel_valid),
    .b_hs_i(b_hs), .outstanding_o(outstanding), .err_o(err)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model state: what the scheduler should look like after each clock edge.
  int  m_rr, m_out, m_sel;
  bit  m_gv, m_err, m_hs, m_pop;
  int  wq[$];
  int  aw_exp_q[$];
  int  w_exp_q[$];
  bit  mon_prev = 1'b0;

  function automatic bit bit_of(logic [N-1:0] v, int i);
    return ((int'(v) >> i) & 1) == 1;
  endfunction

  function automatic int rr_pick(logic [N-1:0] req, int rr);
    for (int i = 0; i < N; i++) begin
      int m = (rr + i) % N;
      if (bit_of(req, m)) return m;
    end
    return -1;
  endfunction

  task automatic model_step(logic [N-1:0] req, bit awr, bit whs, bit wl, bit bhs);
    int out0 = m_out;
    int sz0  = wq.size();
    m_hs  = 1'b0;
    m_pop = 1'b0;
    if (m_gv) begin
      if (bit_of(req, m_sel) && awr) begin
        m_hs = 1'b1;
        m_gv = 1'b0;
        m_rr = (m_sel + 1) % N;
      end else if (!bit_of(req, m_sel)) m_err = 1'b1;
    end else if (req != 0 && out0 < MAX && sz0 < MAX) begin
      m_sel = rr_pick(req, m_rr);
      m_gv  = 1'b1;
      aw_exp_q.push_back(m_sel);
    end
    if (whs && sz0 == 0) m_err = 1'b1;
    if (whs && wl && sz0 > 0) begin
      m_pop = 1'b1;
      void'(wq.pop_front());
    end
    if (m_hs) begin
      wq.push_back(m_sel);
      w_exp_q.push_back(m_sel);
    end
    if (bhs && out0 == 0) m_err = 1'b1;
    m_out = out0 + (m_hs ? 1 : 0) - ((bhs && out0 > 0) ? 1 : 0);
    if (m_out > MAX) m_out = MAX;
    if (m_out < 0) m_out = 0;
  endtask

  task automatic check_state();
    check("aw_sel_valid", int'(aw_sel_valid), int'(m_gv));
    check("outstanding", int'(outstanding), m_out);
    check("err", int'(err), int'(m_err));
    check("w_sel_valid", int'(w_sel_valid), (wq.size() != 0) ? 1 : 0);
    if (wq.size() != 0) check("w_sel_head", int'(w_sel), wq[0]);
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks the result at the next one.
  task automatic step(logic [N-1:0] req, bit awr, bit whs, bit wl, bit bhs);
    aw_req = req; slv_awready = awr; w_hs = whs; wlast = wl; b_hs = bhs;
    #1;
    check("aw_gnt", int'(aw_gnt), (m_gv && awr) ? (1 << m_sel) : 0);
    model_step(req, awr, whs, wl, bhs);
    @(negedge aclk);
    check_state();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    aw_req = '0; slv_awready = 1'b0; w_hs = 1'b0; wlast = 1'b0; b_hs = 1'b0;
    #1;
    check("rst_aw_sel_valid", int'(aw_sel_valid), 0);
    check("rst_aw_gnt", int'(aw_gnt), 0);
    check("rst_aw_sel", int'(aw_sel), 0);
    check("rst_w_sel_valid", int'(w_sel_valid), 0);
    check("rst_w_sel", int'(w_sel), 0);
    check("rst_outstanding", int'(outstanding), 0);
    check("rst_err", int'(err), 0);
    m_rr = 0; m_out = 0; m_sel = 0; m_gv = 1'b0; m_err = 1'b0;
    wq.delete(); aw_exp_q.delete(); w_exp_q.delete();
    repeat (2) @(negedge aclk);
    rst_n = 1'b1;
  endtask

  // Monitor: new grants and W last-beat routing are popped against the expected order queues.
  initial begin
    forever begin
      @(negedge aclk);
      #3;
      if (rst_n) begin
        if (aw_sel_valid && !mon_prev) begin
          check("aw_grant_pending", aw_exp_q.size(), 1);
          if (aw_exp_q.size() > 0) check("aw_grant_order", int'(aw_sel), aw_exp_q.pop_front());
        end
        if (w_hs && wlast && w_sel_valid) begin
          check("w_order_pending", (w_exp_q.size() > 0) ? 1 : 0, 1);
          if (w_exp_q.size() > 0) check("w_order", int'(w_sel), w_exp_q.pop_front());
        end
        mon_prev = aw_sel_valid;
      end else begin
        mon_prev = 1'b0;
      end
    end
  end

  initial begin
    int pend [N];
    int b_pend;
    int awp_t [3] = '{100, 70, 30};
    int wp_t  [3] = '{0, 50, 90};
    int bp_t  [3] = '{0, 30, 90};
    logic [N-1:0] req;

    @(negedge aclk);
    do_reset();

    // Single write: grant, 4-beat burst, response.
    step(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Randomized legal traffic; valid never drops before its handshake.
    foreach (pend[m]) pend[m] = 0;
    b_pend = 0;
    for (int seg = 0; seg < 40; seg++) begin
      int awp = awp_t[$urandom_range(2)];
      int wp  = wp_t[$urandom_range(2)];
      int bp  = bp_t[$urandom_range(2)];
      for (int c = 0; c < 100; c++) begin
        bit awr, whs, wl, bhs;
        req = '0;
        for (int m = 0; m < N; m++) begin
          if ($urandom_range(99) < 20 && pend[m] < 3) pend[m]++;
          if (pend[m] > 0) req = req | N'(1 << m);
        end
        awr = ($urandom_range(99) < awp);
        whs = (wq.size() > 0) && ($urandom_range(99) < wp);
        wl  = ($urandom_range(99) < 40);
        bhs = (b_pend > 0) && ($urandom_range(99) < bp);
        step(req, awr, whs, wl, bhs);
        if (m_hs) pend[m_sel]--;
        if (m_pop) b_pend++;
        if (bhs) b_pend--;
      end
    end

    // B with nothing outstanding.
    do_reset();
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // W beat with empty FIFO.
    do_reset();
    step(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Valid dropped while granted.
    do_reset();
    step(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-GRANT with rr pointing at master 1; master 0 must win afterwards.
    do_reset();
    step(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_sel", int'(aw_sel), 1);
    do_reset();
    step(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_reset_sel", int'(aw_sel), 0);
    step(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
